imm_gen_pipe: RTL and testbench

- Parametrised, registered immediate generator for the ID stage. Successor to the purely combinational extender.
- Decodes immediates for XLEN 32 or 64. Adds a CSR zimm type and carries a sideband tag.
- Buffers results in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so ID can stall or flush without losing or duplicating immediates.

---
 rtl/imm_gen_pipe.sv | 164 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the ID stage.
// Decodes the immediate combinationally and writes it, with its sideband
// tag, into a DEPTH-entry FIFO that has valid/ready handshakes on both sides.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 32
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_inst,
   input  logic [3:0]                 in_sel,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_imm,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       sel_err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      IMM_U     = 3'd0,
      IMM_J     = 3'd1,
      IMM_I     = 3'd2,
      IMM_B     = 3'd3,
      IMM_S     = 3'd4,
      IMM_SHAMT = 3'd5,
      IMM_ZIMM  = 3'd6,
      IMM_BAD   = 3'd7
   } imm_sel_e;

   imm_sel_e          sel;
   logic [31:0]       field;
   int unsigned       fld_w;
   logic              sx;
   logic [XLEN-1:0]   upper_mask;
   logic [XLEN-1:0]   imm_d;

   logic [XLEN-1:0]   imm_mem_q [DEPTH];
   logic [TAG_W-1:0]  tag_mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              sel_err_q, sel_err_d;
   logic              push, pop;

   assign sel = imm_sel_e'(in_sel[2:0]);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Immediate decode: the zero-extended field plus, for signed types, a fill
   // mask above the field MSB. Every signed field has inst[31] as its MSB, so
   // one mask/fill step covers all types and both XLEN values.
   always_comb begin
      field = '0;
      fld_w = 32;
      sx    = 1'b0;
      case (sel)
         IMM_U: begin
            field = {in_inst[31:12], 12'b0};
            fld_w = 32;
            sx    = !in_sel[3];
         end
         IMM_J: begin
            field = {11'b0, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            fld_w = 21;
            sx    = !in_sel[3];
         end
         IMM_I: begin
            field = {20'b0, in_inst[31:20]};
            fld_w = 12;
            sx    = !in_sel[3];
         end
         IMM_B: begin
            field = {19'b0, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            fld_w = 13;
            sx    = 1'b1;
         end
         IMM_S: begin
            field = {20'b0, in_inst[31:25], in_inst[11:7]};
            fld_w = 12;
            sx    = !in_sel[3];
         end
         IMM_SHAMT: begin
            field = (XLEN == 64) ? {26'b0, in_inst[25:20]} : {27'b0, in_inst[24:20]};
         end
         IMM_ZIMM: begin
            field = {27'b0, in_inst[19:15]};
         end
         default: begin
            field = '0;
         end
      endcase
      upper_mask = ~((XLEN'(1) << fld_w) - XLEN'(1));
      imm_d      = XLEN'(field) | ((sx && in_inst[31]) ? upper_mask : '0);
   end

   // Handshake: flush blocks input; a full FIFO still accepts when popping.
   assign out_valid = (count_q != '0);
   assign in_ready  = !flush && ((count_q < CW'(DEPTH)) || (out_ready && (count_q != '0)));
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Next-state for pointers, occupancy and the bad-select pulse.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      sel_err_d = push && (sel == IMM_BAD);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         sel_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         sel_err_q <= sel_err_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads zero afterwards.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            imm_mem_q[i] <= '0;
            tag_mem_q[i] <= '0;
         end
      end else if (push) begin
         imm_mem_q[wr_ptr_q] <= imm_d;
         tag_mem_q[wr_ptr_q] <= in_tag;
      end
   end

   assign out_imm = imm_mem_q[rd_ptr_q];
   assign out_tag = tag_mem_q[rd_ptr_q];
   assign count   = count_q;
   assign sel_err = sel_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors for imm_gen_pipe at XLEN=32 and XLEN=64.
module tb_imm_gen_pipe;

   logic        CLK = 1'b0;
   logic        RESET_N;

   // XLEN=32 instance
   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err;
   logic [31:0] a_in_inst, a_in_tag, a_out_imm, a_out_tag;
   logic [3:0]  a_in_sel;
   logic [1:0]  a_count;

   // XLEN=64 instance
   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err;
   logic [31:0] b_in_inst, b_in_tag, b_out_tag;
   logic [63:0] b_out_imm;
   logic [3:0]  b_in_sel;
   logic [1:0]  b_count;

   int checks = 0;
   int errors = 0;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) u_a (
      .CLK(CLK), .RESET_N(RESET_N), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst),
      .in_sel(a_in_sel), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
      .out_tag(a_out_tag), .count(a_count), .sel_err(a_sel_err)
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) u_b (
      .CLK(CLK), .RESET_N(RESET_N), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
      .in_sel(b_in_sel), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
      .out_tag(b_out_tag), .count(b_count), .sel_err(b_sel_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_a(input logic [31:0] inst, input logic [3:0] sel, input logic [31:0] tag);
      a_in_inst = inst;
      a_in_sel  = sel;
      a_in_tag  = tag;
   endtask

   task automatic drive_b(input logic [31:0] inst, input logic [3:0] sel, input logic [31:0] tag);
      b_in_inst = inst;
      b_in_sel  = sel;
      b_in_tag  = tag;
   endtask

   initial begin
      RESET_N = 1'b0;
      a_flush = 0; a_in_valid = 0; a_out_ready = 0; drive_a('0, '0, '0);
      b_flush = 0; b_in_valid = 0; b_out_ready = 1; drive_b('0, '0, '0);
      #2;
      chk("rst_count",   64'(a_count),     64'd0);
      chk("rst_valid",   64'(a_out_valid), 64'd0);
      chk("rst_imm",     64'(a_out_imm),   64'd0);
      chk("rst_tag",     64'(a_out_tag),   64'd0);
      chk("rst_selerr",  64'(a_sel_err),   64'd0);
      chk("rst_b_valid", 64'(b_out_valid), 64'd0);
      #10 RESET_N = 1'b1;
      step();
      chk("idle_ready",  64'(a_in_ready),  64'd1);

      // Two I-type entries, signed then zero-extended, held until drained.
      a_in_valid = 1; drive_a(32'hFFF00093, 4'h2, 32'h11);
      step();
      chk("i_sx_valid",  64'(a_out_valid), 64'd1);
      chk("i_sx_imm",    64'(a_out_imm),   64'hFFFFFFFF);
      chk("i_sx_tag",    64'(a_out_tag),   64'h11);
      chk("i_sx_count",  64'(a_count),     64'd1);
      drive_a(32'hFFF00093, 4'hA, 32'h22);
      step();
      a_in_valid = 0;
      chk("fill_count",  64'(a_count),     64'd2);
      chk("fill_ready",  64'(a_in_ready),  64'd0);
      chk("head_keep",   64'(a_out_imm),   64'hFFFFFFFF);
      a_out_ready = 1;
      step();
      chk("i_zx_imm",    64'(a_out_imm),   64'h00000FFF);
      chk("i_zx_tag",    64'(a_out_tag),   64'h22);
      chk("drain_count", 64'(a_count),     64'd1);
      step();
      chk("empty_valid", 64'(a_out_valid), 64'd0);

      // Streaming with out_ready=1: each new push replaces the popped head.
      a_in_valid = 1; drive_a(32'hFE000EE3, 4'h3, 32'h31);
      step();
      chk("b_imm",       64'(a_out_imm),   64'hFFFFFFFC);
      chk("b_tag",       64'(a_out_tag),   64'h31);
      drive_a(32'h123450B7, 4'h0, 32'h32);
      step();
      chk("u_imm",       64'(a_out_imm),   64'h12345000);
      chk("u_tag",       64'(a_out_tag),   64'h32);
      chk("pp_count",    64'(a_count),     64'd1);
      drive_a(32'h34011073, 4'h6, 32'h33);
      step();
      chk("zimm_imm",    64'(a_out_imm),   64'h00000002);
      drive_a(32'hFE112E23, 4'h4, 32'h34);
      step();
      chk("s_imm",       64'(a_out_imm),   64'hFFFFFFFC);
      drive_a(32'hFFDFF0EF, 4'h1, 32'h35);
      step();
      chk("j_sx_imm",    64'(a_out_imm),   64'hFFFFFFFC);
      drive_a(32'hFFDFF0EF, 4'h9, 32'h36);
      step();
      chk("j_zx_imm",    64'(a_out_imm),   64'h001FFFFC);
      chk("no_selerr",   64'(a_sel_err),   64'd0);
      drive_a(32'hFFFFFFFF, 4'h7, 32'h37);
      step();
      a_in_valid = 0;
      chk("bad_imm",     64'(a_out_imm),   64'd0);
      chk("bad_tag",     64'(a_out_tag),   64'h37);
      chk("selerr_hi",   64'(a_sel_err),   64'd1);
      step();
      chk("selerr_lo",   64'(a_sel_err),   64'd0);
      chk("stream_end",  64'(a_count),     64'd0);

      // XLEN=64 vectors.
      b_in_valid = 1; drive_b(32'h800000B7, 4'h0, 32'h41);
      step();
      chk("b64_u_sx",    b_out_imm,        64'hFFFFFFFF80000000);
      chk("b64_u_tag",   64'(b_out_tag),   64'h41);
      drive_b(32'h800000B7, 4'h8, 32'h42);
      step();
      chk("b64_u_zx",    b_out_imm,        64'h0000000080000000);
      drive_b(32'h03F0D093, 4'h5, 32'h43);
      step();
      chk("b64_shamt",   b_out_imm,        64'h000000000000003F);
      drive_b(32'hFFF00093, 4'h2, 32'h44);
      step();
      chk("b64_i_sx",    b_out_imm,        64'hFFFFFFFFFFFFFFFF);
      drive_b(32'hFE000EE3, 4'hB, 32'h45);
      step();
      b_in_valid = 0;
      chk("b64_b_sx",    b_out_imm,        64'hFFFFFFFFFFFFFFFC);
      step();
      chk("b64_empty",   64'(b_out_valid), 64'd0);

      // Full FIFO, third entry held, then push and pop in the same cycle.
      a_out_ready = 0;
      a_in_valid = 1; drive_a(32'h00100093, 4'h2, 32'h1);
      step();
      drive_a(32'h00200093, 4'h2, 32'h2);
      step();
      drive_a(32'h00300093, 4'h2, 32'h3);
      step();
      chk("full_count",  64'(a_count),     64'd2);
      chk("full_ready",  64'(a_in_ready),  64'd0);
      chk("full_head",   64'(a_out_tag),   64'h1);
      a_out_ready = 1;
      #1;
      chk("credit_rdy",  64'(a_in_ready),  64'd1);
      step();
      a_in_valid = 0;
      chk("pp_full_cnt", 64'(a_count),     64'd2);
      chk("pp_full_tag", 64'(a_out_tag),   64'h2);
      chk("pp_full_imm", 64'(a_out_imm),   64'h2);
      step();
      chk("ord3_tag",    64'(a_out_tag),   64'h3);
      chk("ord3_imm",    64'(a_out_imm),   64'h3);
      step();
      chk("full_drain",  64'(a_count),     64'd0);

      // Flush with a full FIFO and a bad-select entry on the input.
      a_out_ready = 0;
      a_in_valid = 1; drive_a(32'h00400093, 4'h2, 32'h4);
      step();
      drive_a(32'h00500093, 4'h2, 32'h5);
      step();
      chk("pre_flush",   64'(a_count),     64'd2);
      drive_a(32'h00000000, 4'h7, 32'h9);
      a_out_ready = 1; a_flush = 1;
      #1;
      chk("flush_rdy",   64'(a_in_ready),  64'd0);
      step();
      a_flush = 0; a_out_ready = 0;
      chk("flush_cnt",   64'(a_count),     64'd0);
      chk("flush_valid", 64'(a_out_valid), 64'd0);
      chk("flush_selerr",64'(a_sel_err),   64'd0);
      drive_a(32'h00600093, 4'h2, 32'h6);
      step();
      a_in_valid = 0;
      chk("post_valid",  64'(a_out_valid), 64'd1);
      chk("post_imm",    64'(a_out_imm),   64'h6);
      chk("post_tag",    64'(a_out_tag),   64'h6);
      chk("post_cnt",    64'(a_count),     64'd1);

      // Asynchronous reset with one entry buffered.
      RESET_N = 1'b0;
      #1;
      chk("areset_valid", 64'(a_out_valid), 64'd0);
      chk("areset_cnt",   64'(a_count),     64'd0);
      chk("areset_imm",   64'(a_out_imm),   64'd0);
      #6 RESET_N = 1'b1;
      step();
      chk("after_rst",    64'(a_out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
